// File: rtl/param_scoreboard_if.sv
// Issue, operand-read and write-back signal bundle between the scoreboard,
// its instruction source and the functional units it controls.
interface param_scoreboard_if #(
    parameter int NUM_FUS   = 4,
    parameter int REG_BITS  = 5,
    parameter int FU_BITS   = 2,
    parameter int TYPE_BITS = 2
);
    logic                 flush;
    logic                 inst_valid;
    logic                 inst_ready;
    logic [TYPE_BITS-1:0] inst_type;
    logic [REG_BITS-1:0]  inst_fi;
    logic [REG_BITS-1:0]  inst_fj;
    logic [REG_BITS-1:0]  inst_fk;
    logic [FU_BITS-1:0]   issue_fu;
    logic [NUM_FUS-1:0]   read_grant;
    logic [NUM_FUS-1:0]   exec_done;
    logic                 wb_valid;
    logic [FU_BITS-1:0]   wb_fu;
    logic [REG_BITS-1:0]  wb_reg;
    logic [NUM_FUS-1:0]   fu_busy;
    logic                 stall_struct;
    logic                 stall_waw;

    modport master (
        output flush, inst_valid, inst_type, inst_fi, inst_fj, inst_fk, exec_done,
        input  inst_ready, issue_fu, read_grant, wb_valid, wb_fu, wb_reg,
               fu_busy, stall_struct, stall_waw
    );

    modport slave (
        input  flush, inst_valid, inst_type, inst_fi, inst_fj, inst_fk, exec_done,
        output inst_ready, issue_fu, read_grant, wb_valid, wb_fu, wb_reg,
               fu_busy, stall_struct, stall_waw
    );
endinterface

// File: rtl/param_scoreboard.sv
// CDC 6600-style scoreboard control: per-FU issue/read/execute/write-back
// sequencing with RAW, WAW, WAR and structural hazard checks.
//
// state      | meaning
// S_IDLE     | FU free, may accept an issue of its type
// S_WAIT_OPS | issued, waiting for both source operands (Rj & Rk)
// S_EXEC     | operands read, waiting for the FU's exec_done pulse
// S_WAIT_WB  | result ready, waiting for a WAR-free write-back grant
module param_scoreboard #(
    parameter int NUM_FUS   = 4,
    parameter int NUM_REGS  = 32,
    parameter int REG_BITS  = 5,
    parameter int FU_BITS   = 2,
    parameter int TYPE_BITS = 2,
    parameter logic [NUM_FUS*TYPE_BITS-1:0] FU_TYPE_MAP = {2'd3, 2'd2, 2'd0, 2'd0}
) (
    input logic               clk,
    input logic               rst_n,
    param_scoreboard_if.slave sb
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_OPS, S_EXEC, S_WAIT_WB} fu_state_t;

    fu_state_t           state_q [NUM_FUS];
    fu_state_t           state_d [NUM_FUS];
    logic [REG_BITS-1:0] fi_q [NUM_FUS];
    logic [REG_BITS-1:0] fj_q [NUM_FUS];
    logic [REG_BITS-1:0] fk_q [NUM_FUS];
    logic [FU_BITS-1:0]  qj_q [NUM_FUS];
    logic [FU_BITS-1:0]  qk_q [NUM_FUS];
    logic [NUM_FUS-1:0]  qj_v_q, qk_v_q, rj_q, rk_q;
    logic [FU_BITS-1:0]  rs_fu_q [NUM_REGS];
    logic [NUM_REGS-1:0] rs_v_q;
    logic [FU_BITS-1:0]  rr_ptr_q;

    logic               out_en, any_free, issue_ok, wb_found, wb_grant;
    logic               j_pend, k_pend;
    logic [FU_BITS-1:0] sel_fu, wb_sel, rr_next;
    logic [NUM_FUS-1:0] free_match, rd_grant, wb_elig, busy;
    int                 idx;

    assign out_en = rst_n & ~sb.flush;

    // Descending scan so the lowest matching free FU wins.
    always_comb begin : issue_select
        any_free   = 1'b0;
        sel_fu     = '0;
        free_match = '0;
        for (int i = NUM_FUS - 1; i >= 0; i--) begin
            free_match[i] = (state_q[i] == S_IDLE) &&
                            (FU_TYPE_MAP[i*TYPE_BITS +: TYPE_BITS] == sb.inst_type);
            if (free_match[i]) begin
                any_free = 1'b1;
                sel_fu   = FU_BITS'(i);
            end
        end
    end

    assign issue_ok = sb.inst_valid & any_free & ~rs_v_q[sb.inst_fi] & out_en;
    assign j_pend   = rs_v_q[sb.inst_fj] & ~(wb_grant && rs_fu_q[sb.inst_fj] == wb_sel);
    assign k_pend   = rs_v_q[sb.inst_fk] & ~(wb_grant && rs_fu_q[sb.inst_fk] == wb_sel);

    always_comb begin : read_and_writeback
        rd_grant = '0;
        wb_elig  = '0;
        wb_found = 1'b0;
        wb_sel   = '0;
        idx      = 0;
        for (int i = 0; i < NUM_FUS; i++) begin
            rd_grant[i] = out_en && (state_q[i] == S_WAIT_OPS) && rj_q[i] && rk_q[i];
            wb_elig[i]  = (state_q[i] == S_WAIT_WB);
            // A pending reader still needing the old value of Fi blocks the write.
            for (int j = 0; j < NUM_FUS; j++) begin
                if (j != i && state_q[j] == S_WAIT_OPS &&
                    ((fj_q[j] == fi_q[i] && rj_q[j]) || (fk_q[j] == fi_q[i] && rk_q[j])))
                    wb_elig[i] = 1'b0;
            end
        end
        for (int k = 0; k < NUM_FUS; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_FUS;
            if (!wb_found && wb_elig[idx]) begin
                wb_found = 1'b1;
                wb_sel   = FU_BITS'(idx);
            end
        end
    end

    assign wb_grant = wb_found & out_en;
    assign rr_next  = (wb_sel == FU_BITS'(NUM_FUS - 1)) ? '0 : wb_sel + FU_BITS'(1);

    always_comb begin : fsm_next
        for (int i = 0; i < NUM_FUS; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE:     if (issue_ok && sel_fu == FU_BITS'(i)) state_d[i] = S_WAIT_OPS;
                S_WAIT_OPS: if (rd_grant[i])                       state_d[i] = S_EXEC;
                S_EXEC:     if (sb.exec_done[i])                   state_d[i] = S_WAIT_WB;
                S_WAIT_WB:  if (wb_grant && wb_sel == FU_BITS'(i)) state_d[i] = S_IDLE;
                default:                                           state_d[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin : busy_flags
        busy = '0;
        for (int i = 0; i < NUM_FUS; i++) busy[i] = out_en && (state_q[i] != S_IDLE);
    end

    assign sb.inst_ready   = issue_ok;
    assign sb.issue_fu     = issue_ok ? sel_fu : '0;
    assign sb.read_grant   = rd_grant;
    assign sb.wb_valid     = wb_grant;
    assign sb.wb_fu        = wb_grant ? wb_sel : '0;
    assign sb.wb_reg       = wb_grant ? fi_q[wb_sel] : '0;
    assign sb.fu_busy      = busy;
    assign sb.stall_struct = out_en & sb.inst_valid & ~any_free;
    assign sb.stall_waw    = out_en & sb.inst_valid & rs_v_q[sb.inst_fi];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FUS; i++) begin
                state_q[i] <= S_IDLE;
                fi_q[i]    <= '0;
                fj_q[i]    <= '0;
                fk_q[i]    <= '0;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
            end
            for (int r = 0; r < NUM_REGS; r++) rs_fu_q[r] <= '0;
            qj_v_q   <= '0;
            qk_v_q   <= '0;
            rj_q     <= '0;
            rk_q     <= '0;
            rs_v_q   <= '0;
            rr_ptr_q <= '0;
        end else if (sb.flush) begin
            for (int i = 0; i < NUM_FUS; i++) state_q[i] <= S_IDLE;
            qj_v_q   <= '0;
            qk_v_q   <= '0;
            rj_q     <= '0;
            rk_q     <= '0;
            rs_v_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            for (int i = 0; i < NUM_FUS; i++) state_q[i] <= state_d[i];
            if (wb_grant) begin
                rs_v_q[fi_q[wb_sel]] <= 1'b0;
                rr_ptr_q             <= rr_next;
            end
            if (issue_ok) begin
                rs_v_q[sb.inst_fi]  <= 1'b1;
                rs_fu_q[sb.inst_fi] <= sel_fu;
            end
            for (int i = 0; i < NUM_FUS; i++) begin
                if (wb_grant && qj_v_q[i] && qj_q[i] == wb_sel) begin
                    rj_q[i]   <= 1'b1;
                    qj_v_q[i] <= 1'b0;
                end
                if (wb_grant && qk_v_q[i] && qk_q[i] == wb_sel) begin
                    rk_q[i]   <= 1'b1;
                    qk_v_q[i] <= 1'b0;
                end
                if (rd_grant[i]) begin
                    rj_q[i] <= 1'b0;
                    rk_q[i] <= 1'b0;
                end
                if (issue_ok && sel_fu == FU_BITS'(i)) begin
                    fi_q[i]   <= sb.inst_fi;
                    fj_q[i]   <= sb.inst_fj;
                    fk_q[i]   <= sb.inst_fk;
                    qj_q[i]   <= rs_fu_q[sb.inst_fj];
                    qk_q[i]   <= rs_fu_q[sb.inst_fk];
                    qj_v_q[i] <= j_pend;
                    qk_v_q[i] <= k_pend;
                    rj_q[i]   <= ~j_pend;
                    rk_q[i]   <= ~k_pend;
                end
            end
        end
    end
endmodule

// File: tb/tb_param_scoreboard.sv
// Directed hazard scenarios plus randomized traffic, checked every cycle
// against an instruction-level model of the scoreboard rules.
module tb_param_scoreboard;
    localparam int NF = 4;
    localparam int NR = 32;
    localparam int RB = 5;
    localparam int FB = 2;
    localparam int TW = 2;
    localparam logic [NF*TW-1:0] TMAP = {2'd3, 2'd2, 2'd0, 2'd0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    param_scoreboard_if #(.NUM_FUS(NF), .REG_BITS(RB), .FU_BITS(FB), .TYPE_BITS(TW)) sb ();

    param_scoreboard #(
        .NUM_FUS(NF), .NUM_REGS(NR), .REG_BITS(RB), .FU_BITS(FB),
        .TYPE_BITS(TW), .FU_TYPE_MAP(TMAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sb(sb)
    );

    always #5 clk = ~clk;

    // Model: each FU slot holds one in-flight instruction identified by a
    // sequence number; operands wait on the producing instruction, not a tag.
    bit m_busy [NF];
    bit m_rd   [NF];
    bit m_fin  [NF];
    int m_dst  [NF];
    int m_s1   [NF];
    int m_s2   [NF];
    int m_p1   [NF];
    int m_p2   [NF];
    int m_seq  [NF];
    int last_wr [NR];
    int rr_p;
    int seq_ctr;

    logic          e_ready, e_wbv, e_ss, e_sw;
    logic [FB-1:0] e_issue, e_wbfu;
    logic [RB-1:0] e_wbreg;
    logic [NF-1:0] e_rg, e_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit live(input int s);
        if (s < 0) return 1'b0;
        for (int i = 0; i < NF; i++) if (m_busy[i] && m_seq[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_busy();
        for (int i = 0; i < NF; i++) if (m_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin
            m_busy[i] = 0; m_rd[i] = 0; m_fin[i] = 0;
        end
        for (int r = 0; r < NR; r++) last_wr[r] = -1;
        rr_p = 0;
    endtask

    task automatic model_eval();
        int  first;
        int  idx;
        bit  elig [NF];
        e_ready = 0; e_wbv = 0; e_ss = 0; e_sw = 0;
        e_issue = '0; e_wbfu = '0; e_wbreg = '0; e_rg = '0; e_busy = '0;
        if (sb.flush) return;
        first = -1;
        for (int i = NF - 1; i >= 0; i--)
            if (!m_busy[i] && TMAP[i*TW +: TW] == sb.inst_type) first = i;
        for (int i = 0; i < NF; i++) e_busy[i] = m_busy[i];
        if (sb.inst_valid) begin
            e_ss    = (first < 0);
            e_sw    = (last_wr[sb.inst_fi] >= 0);
            e_ready = !e_ss && !e_sw;
            if (e_ready) e_issue = FB'(first);
        end
        for (int i = 0; i < NF; i++) begin
            e_rg[i] = m_busy[i] && !m_rd[i] && !live(m_p1[i]) && !live(m_p2[i]);
            elig[i] = m_busy[i] && m_fin[i];
            for (int j = 0; j < NF; j++)
                if (j != i && m_busy[j] && !m_rd[j] &&
                    ((m_s1[j] == m_dst[i] && !live(m_p1[j])) ||
                     (m_s2[j] == m_dst[i] && !live(m_p2[j]))))
                    elig[i] = 0;
        end
        for (int k = 0; k < NF; k++) begin
            idx = (rr_p + k) % NF;
            if (!e_wbv && elig[idx]) begin
                e_wbv   = 1;
                e_wbfu  = FB'(idx);
                e_wbreg = RB'(m_dst[idx]);
            end
        end
    endtask

    task automatic model_commit();
        int w;
        bit ed [NF];
        if (sb.flush) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NF; i++)
            ed[i] = sb.exec_done[i] && m_busy[i] && m_rd[i] && !m_fin[i];
        if (e_wbv) begin
            w = int'(e_wbfu);
            last_wr[m_dst[w]] = -1;
            m_busy[w] = 0;
            rr_p = (w + 1) % NF;
        end
        for (int i = 0; i < NF; i++) if (ed[i]) m_fin[i] = 1;
        for (int i = 0; i < NF; i++) if (e_rg[i]) m_rd[i] = 1;
        if (e_ready) begin
            w = int'(e_issue);
            m_busy[w] = 1; m_rd[w] = 0; m_fin[w] = 0;
            m_dst[w] = int'(sb.inst_fi);
            m_s1[w]  = int'(sb.inst_fj);
            m_s2[w]  = int'(sb.inst_fk);
            m_p1[w]  = last_wr[m_s1[w]];
            m_p2[w]  = last_wr[m_s2[w]];
            m_seq[w] = seq_ctr;
            last_wr[m_dst[w]] = seq_ctr;
            seq_ctr++;
        end
    endtask

    // Called shortly after a rising edge with inputs already driven.
    task automatic step();
        #2;
        model_eval();
        chk("inst_ready",   32'(sb.inst_ready),   32'(e_ready));
        chk("read_grant",   32'(sb.read_grant),   32'(e_rg));
        chk("wb_valid",     32'(sb.wb_valid),     32'(e_wbv));
        chk("fu_busy",      32'(sb.fu_busy),      32'(e_busy));
        chk("stall_struct", 32'(sb.stall_struct), 32'(e_ss));
        chk("stall_waw",    32'(sb.stall_waw),    32'(e_sw));
        if (e_ready || sb.flush) chk("issue_fu", 32'(sb.issue_fu), 32'(e_issue));
        if (e_wbv || sb.flush) begin
            chk("wb_fu",  32'(sb.wb_fu),  32'(e_wbfu));
            chk("wb_reg", 32'(sb.wb_reg), 32'(e_wbreg));
        end
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic offer(input int t, input int fi, input int fj, input int fk);
        sb.inst_valid = 1'b1;
        sb.inst_type  = TW'(t);
        sb.inst_fi    = RB'(fi);
        sb.inst_fj    = RB'(fj);
        sb.inst_fk    = RB'(fk);
    endtask

    task automatic quiet();
        sb.inst_valid = 1'b0;
        sb.exec_done  = '0;
        sb.flush      = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        quiet();
        while (any_busy() && n < 60) begin
            sb.exec_done = '1;
            step();
            n++;
        end
        sb.exec_done = '0;
        #1;
        chk("drain_idle", 32'(sb.fu_busy), 32'(0));
    endtask

    // Three instructions on FU0, FU1, FU2 brought to WAIT_WB together.
    task automatic three_to_wb(input int base);
        offer(0, base, 1, 2);     step();
        offer(0, base + 1, 1, 2); step();
        offer(2, base + 2, 1, 2); step();
        quiet();                  step();
        sb.exec_done = 4'b0111;   step();
        sb.exec_done = '0;
    endtask

    int ord_a [3] = '{0, 1, 2};
    int ord_b [3] = '{1, 2, 0};

    initial begin
        quiet();
        sb.exec_done = '1;
        offer(0, 1, 2, 3);
        seq_ctr = 0;
        model_reset();
        #3;
        chk("rst_ready",      32'(sb.inst_ready),   32'(0));
        chk("rst_busy",       32'(sb.fu_busy),      32'(0));
        chk("rst_read_grant", 32'(sb.read_grant),   32'(0));
        chk("rst_wb_valid",   32'(sb.wb_valid),     32'(0));
        chk("rst_stall_waw",  32'(sb.stall_waw),    32'(0));
        offer(1, 1, 2, 3);
        #1;
        chk("rst_stall_struct", 32'(sb.stall_struct), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        quiet();

        // Independent issue
        offer(0, 1, 2, 3); #1;
        chk("ind_ready", 32'(sb.inst_ready), 32'(1));
        chk("ind_issue_fu", 32'(sb.issue_fu), 32'(0));
        step();
        quiet(); #1;
        chk("ind_read_grant", 32'(sb.read_grant), 32'(4'b0001));
        step();
        sb.exec_done = 4'b0001; step();
        sb.exec_done = '0; #1;
        chk("ind_wb_valid", 32'(sb.wb_valid), 32'(1));
        chk("ind_wb_fu", 32'(sb.wb_fu), 32'(0));
        chk("ind_wb_reg", 32'(sb.wb_reg), 32'(1));
        step();
        #1;
        chk("ind_busy_clear", 32'(sb.fu_busy), 32'(0));
        step();

        // RAW through a long DIV
        offer(3, 4, 5, 6); step();
        offer(0, 7, 4, 1); step();
        quiet(); #1;
        chk("raw_hold", 32'(sb.read_grant), 32'(0));
        step();
        step();
        sb.exec_done = 4'b1000; step();
        sb.exec_done = '0; #1;
        chk("raw_div_wb_valid", 32'(sb.wb_valid), 32'(1));
        chk("raw_div_wb_fu", 32'(sb.wb_fu), 32'(3));
        chk("raw_hold_at_wb", 32'(sb.read_grant), 32'(0));
        step();
        #1;
        chk("raw_release", 32'(sb.read_grant), 32'(4'b0001));
        step();
        drain();

        // WAW and structural stalls
        offer(2, 8, 1, 2); step();
        offer(0, 8, 3, 4); #1;
        chk("waw_stall", 32'(sb.stall_waw), 32'(1));
        chk("waw_ready", 32'(sb.inst_ready), 32'(0));
        step();
        offer(0, 9, 1, 1);  step();
        offer(0, 10, 1, 2); step();
        offer(0, 11, 3, 3); #1;
        chk("struct_stall", 32'(sb.stall_struct), 32'(1));
        chk("struct_ready", 32'(sb.inst_ready), 32'(0));
        step();
        drain();

        // WAR: early ADD r1 must wait for the reader of old r1
        offer(3, 2, 9, 10); step();
        offer(0, 3, 2, 1);  step();
        offer(0, 1, 4, 5);  step();
        quiet();            step();
        sb.exec_done = 4'b0010; step();
        sb.exec_done = '0; #1;
        chk("war_hold", 32'(sb.wb_valid), 32'(0));
        step();
        sb.exec_done = 4'b1000; step();
        sb.exec_done = '0; #1;
        chk("war_div_wb_fu", 32'(sb.wb_fu), 32'(3));
        step();
        #1;
        chk("war_reader_grant", 32'(sb.read_grant), 32'(4'b0001));
        chk("war_still_held", 32'(sb.wb_valid), 32'(0));
        step();
        #1;
        chk("war_release_valid", 32'(sb.wb_valid), 32'(1));
        chk("war_release_fu", 32'(sb.wb_fu), 32'(1));
        chk("war_release_reg", 32'(sb.wb_reg), 32'(1));
        step();
        drain();

        // Round-robin from pointer 0, then from pointer 1
        sb.flush = 1'b1; step();
        quiet();
        three_to_wb(11);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("rr_from0_%0d", k), 32'(sb.wb_fu), 32'(ord_a[k]));
            step();
        end
        offer(0, 14, 1, 2);     step();
        quiet();                step();
        sb.exec_done = 4'b0001; step();
        sb.exec_done = '0;      step();
        three_to_wb(15);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("rr_from1_%0d", k), 32'(sb.wb_fu), 32'(ord_b[k]));
            step();
        end
        drain();

        // Flush with three FUs in flight
        offer(0, 20, 1, 2); step();
        offer(0, 21, 3, 4); step();
        offer(3, 22, 5, 6); step();
        sb.flush = 1'b1;
        offer(0, 23, 1, 2); #1;
        chk("flush_ready", 32'(sb.inst_ready), 32'(0));
        chk("flush_busy", 32'(sb.fu_busy), 32'(0));
        step();
        sb.flush = 1'b0;
        sb.exec_done = '1;
        offer(0, 24, 1, 2); #1;
        chk("post_flush_busy", 32'(sb.fu_busy), 32'(0));
        chk("post_flush_wb", 32'(sb.wb_valid), 32'(0));
        chk("post_flush_ready", 32'(sb.inst_ready), 32'(1));
        chk("post_flush_issue_fu", 32'(sb.issue_fu), 32'(0));
        step();
        quiet(); #1;
        chk("late_done_ignored", 32'(sb.fu_busy), 32'(4'b0001));
        step();
        drain();

        // Randomized traffic over a small register window to force hazards
        for (int c = 0; c < 400; c++) begin
            sb.flush      = ($urandom_range(0, 39) == 0);
            sb.inst_valid = 1'($urandom_range(0, 1));
            sb.inst_type  = TW'($urandom_range(0, 3));
            sb.inst_fi    = RB'($urandom_range(0, 7));
            sb.inst_fj    = RB'($urandom_range(0, 7));
            sb.inst_fk    = RB'($urandom_range(0, 7));
            sb.exec_done  = NF'($urandom);
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
